// File: rtl/plru_array.sv
// -----------------------------------------------------------------------------
// plru_array
//   Tree pseudo-LRU replacement state for a set-associative structure.
//   Each set keeps NUM_WAYS-1 tree bits, heap-indexed. Node 0 is the root.
//   Node i has children 2i+1 (left) and 2i+2 (right). The leaves are ways
//   0..NUM_WAYS-1 in order. A node bit of 0 points the victim into the left
//   subtree and a bit of 1 points it into the right subtree.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   access_valid  records a hit or fill of access_way in access_set
//   access_set    set being accessed
//   access_way    way being accessed
//   victim_req    asks for the replacement way of victim_set
//   victim_set    set being queried
//   victim_valid  registered; high the cycle after an accepted victim_req
//   victim_way    registered replacement way; holds when victim_valid is low
//   flush_req     starts clearing every set, one set per cycle
//   busy          flush in progress; all requests are ignored meanwhile
// -----------------------------------------------------------------------------
module plru_array #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        access_valid,
    input  logic [$clog2(NUM_SETS)-1:0] access_set,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    input  logic                        victim_req,
    input  logic [$clog2(NUM_SETS)-1:0] victim_set,
    output logic                        victim_valid,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    input  logic                        flush_req,
    output logic                        busy
);

    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int NODES = NUM_WAYS - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   cnt_q, cnt_d;

    logic               acc_en;
    logic               vic_en;
    logic [NODES-1:0]   tree_bits [NUM_SETS];
    logic [NODES-1:0]   acc_cur;
    logic [NODES-1:0]   acc_upd;
    logic [NODES-1:0]   vic_cur;
    logic [NODES-1:0]   vic_bits;
    logic [WAY_W-1:0]   match [NUM_WAYS];
    logic [NUM_WAYS-1:0] hit;
    logic [WAY_W-1:0]   enc [NUM_WAYS+1];
    logic [WAY_W-1:0]   victim_calc;

    logic               victim_valid_q, victim_valid_d;
    logic [WAY_W-1:0]   victim_way_q, victim_way_d;

    assign busy         = (state_q == FLUSH);
    assign acc_en       = access_valid && !busy;
    assign vic_en       = victim_req && !busy;
    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;

    // -------------------------------------------------------------------------
    // Flush sequencer: cnt_q names the set cleared in the current busy cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Access update. Node gi sits at level LV, position POS within that level.
    // It lies on the root-to-leaf path of access_way exactly when the top LV
    // bits of the way equal POS; the next way bit then says which child the
    // access went to, and the node is pointed at the other one.
    // -------------------------------------------------------------------------
    assign acc_cur = tree_bits[access_set];

    generate
        for (genvar gi = 0; gi < NODES; gi++) begin : g_upd
            localparam int LV  = $clog2(gi + 2) - 1;
            localparam int POS = gi + 1 - (1 << LV);
            assign acc_upd[gi] = ((access_way >> (WAY_W - LV)) == WAY_W'(POS))
                               ? ~access_way[WAY_W-1-LV] : acc_cur[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Victim walk. A same-cycle access to the queried set is forwarded so the
    // answer reflects the post-update tree.
    // -------------------------------------------------------------------------
    assign vic_cur  = tree_bits[victim_set];
    assign vic_bits = (acc_en && (access_set == victim_set)) ? acc_upd : vic_cur;

    // Way gi is the victim when every node on its path points toward it.
    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            for (genvar gj = 0; gj < WAY_W; gj++) begin : g_lvl
                localparam int NODE = (1 << gj) - 1 + (gi >> (WAY_W - gj));
                localparam int DIR  = (gi >> (WAY_W - 1 - gj)) & 1;
                assign match[gi][gj] = (vic_bits[NODE] == 1'(DIR));
            end
            assign hit[gi] = &match[gi];
        end
    endgenerate

    // Exactly one leaf hits, so OR-encoding its index is sufficient.
    assign enc[0] = '0;
    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_enc
            assign enc[gi+1] = enc[gi] | (hit[gi] ? WAY_W'(gi) : '0);
        end
    endgenerate
    assign victim_calc = enc[NUM_WAYS];

    always_comb begin
        victim_valid_d = vic_en;
        victim_way_d   = victim_way_q;
        if (vic_en) begin
            victim_way_d = victim_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-set tree storage. A flush clear and an accepted access can never
    // coincide: accesses are only accepted while not busy.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
            logic [NODES-1:0] bits_q, bits_d;

            always_comb begin
                bits_d = bits_q;
                if (busy && (cnt_q == SET_W'(gi))) begin
                    bits_d = '0;
                end else if (acc_en && (access_set == SET_W'(gi))) begin
                    bits_d = acc_upd;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bits_q <= '0;
                end else begin
                    bits_q <= bits_d;
                end
            end

            assign tree_bits[gi] = bits_q;
        end
    endgenerate

endmodule

// File: tb/tb_plru_array.sv
// -----------------------------------------------------------------------------
// tb_plru_array
//   Three plru_array instances: 16 sets x 4 ways (directed + random),
//   8 sets x 16 ways and 4 sets x 2 ways (random). A range-halving tree
//   model per instance predicts every victim.
// -----------------------------------------------------------------------------
module tb_plru_array;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: 16 sets, 4 ways
    logic       a_valid0 = 0, v_req0 = 0, flush0 = 0, vv0, busy0;
    logic [3:0] a_set0 = '0, v_set0 = '0;
    logic [1:0] a_way0 = '0, vw0;
    // instance 1: 8 sets, 16 ways
    logic       a_valid1 = 0, v_req1 = 0, flush1 = 0, vv1, busy1;
    logic [2:0] a_set1 = '0, v_set1 = '0;
    logic [3:0] a_way1 = '0, vw1;
    // instance 2: 4 sets, 2 ways
    logic       a_valid2 = 0, v_req2 = 0, flush2 = 0, vv2, busy2;
    logic [1:0] a_set2 = '0, v_set2 = '0;
    logic [0:0] a_way2 = '0, vw2;

    plru_array #(.NUM_SETS(16), .NUM_WAYS(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .access_valid(a_valid0), .access_set(a_set0), .access_way(a_way0),
        .victim_req(v_req0), .victim_set(v_set0),
        .victim_valid(vv0), .victim_way(vw0),
        .flush_req(flush0), .busy(busy0)
    );

    plru_array #(.NUM_SETS(8), .NUM_WAYS(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .access_valid(a_valid1), .access_set(a_set1), .access_way(a_way1),
        .victim_req(v_req1), .victim_set(v_set1),
        .victim_valid(vv1), .victim_way(vw1),
        .flush_req(flush1), .busy(busy1)
    );

    plru_array #(.NUM_SETS(4), .NUM_WAYS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .access_valid(a_valid2), .access_set(a_set2), .access_way(a_way2),
        .victim_req(v_req2), .victim_set(v_set2),
        .victim_valid(vv2), .victim_way(vw2),
        .flush_req(flush2), .busy(busy2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int ways_of [3] = '{4, 16, 2};
    bit mtree [3][16][15];
    int exp_vw [3] = '{0, 0, 0};

    function automatic void m_clear(input int k);
        for (int s = 0; s < 16; s++)
            for (int n = 0; n < 15; n++)
                mtree[k][s][n] = 1'b0;
    endfunction

    // Narrow [lo,hi) to the accessed way; each node visited points to the
    // half that was not touched.
    function automatic void m_access(input int k, input int set, input int way);
        int lo = 0;
        int hi = ways_of[k];
        int node = 0;
        int mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (way < mid) begin
                mtree[k][set][node] = 1'b1;
                hi = mid;
                node = 2 * node + 1;
            end else begin
                mtree[k][set][node] = 1'b0;
                lo = mid;
                node = 2 * node + 2;
            end
        end
    endfunction

    function automatic int m_victim(input int k, input int set);
        int lo = 0;
        int hi = ways_of[k];
        int node = 0;
        int mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mtree[k][set][node]) begin
                lo = mid;
                node = 2 * node + 2;
            end else begin
                hi = mid;
                node = 2 * node + 1;
            end
        end
        return lo;
    endfunction

    function automatic void m_reset_all();
        for (int k = 0; k < 3; k++) begin
            m_clear(k);
            exp_vw[k] = 0;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc0(input int set, input int way);
        a_valid0 = 1'b1;
        a_set0   = 4'(set);
        a_way0   = 2'(way);
        tick();
        a_valid0 = 1'b0;
        m_access(0, set, way);
        $display("txn access set=%0d way=%0d", set, way);
    endtask

    task automatic vic0(input int set, input int exp, input string tag);
        v_req0 = 1'b1;
        v_set0 = 4'(set);
        tick();
        v_req0 = 1'b0;
        check({tag, "_valid"}, int'(vv0), 1);
        check(tag, int'(vw0), exp);
        exp_vw[0] = exp;
        $display("txn victim set=%0d way=%0d", set, vw0);
    endtask

    int cnt;
    int same;

    initial begin
        // ---------------- reset state ----------------
        m_reset_all();
        #12;
        check("rst_busy", int'(busy0), 0);
        check("rst_vv0", int'(vv0), 0);
        check("rst_vw0", int'(vw0), 0);
        check("rst_vv1", int'(vv1), 0);
        check("rst_vv2", int'(vv2), 0);
        rst_n = 1'b1;

        // fresh set victim is way 0
        vic0(3, 0, "fresh_s3");

        // sequence on set 5
        acc0(5, 0);
        vic0(5, 2, "s5_after_w0");
        acc0(5, 2);
        vic0(5, 1, "s5_after_w2");
        acc0(5, 1);
        vic0(5, 3, "s5_after_w1");

        // idle cycle: valid drops, way holds
        tick();
        check("idle_valid", int'(vv0), 0);
        check("idle_hold", int'(vw0), 3);

        // forwarding: access and query the same set in one cycle
        a_valid0 = 1'b1; a_set0 = 4'd7; a_way0 = 2'd0;
        m_access(0, 7, 0);
        vic0(7, 2, "fwd_s7");
        a_valid0 = 1'b0;

        // access and query of different sets in one cycle
        a_valid0 = 1'b1; a_set0 = 4'd8; a_way0 = 2'd3;
        m_access(0, 8, 3);
        vic0(5, 3, "diff_set_s5");
        a_valid0 = 1'b0;
        vic0(8, m_victim(0, 8), "diff_set_s8");

        // ---------------- flush ----------------
        acc0(0, 0);
        acc0(9, 0);
        acc0(15, 0);
        vic0(9, 2, "pre_flush_s9");
        check("pre_flush_busy", int'(busy0), 0);
        // flush together with an access: access lands, then gets cleared
        flush0 = 1'b1;
        a_valid0 = 1'b1; a_set0 = 4'd1; a_way0 = 2'd0;
        tick();
        flush0 = 1'b0;
        a_valid0 = 1'b0;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            cnt++;
            check("busy_no_valid", int'(vv0), 0);
            a_valid0 = (cnt == 3);
            a_set0   = 4'd9;
            a_way0   = 2'd3;
            v_req0   = (cnt == 3);
            v_set0   = 4'd9;
            flush0   = (cnt == 5);
            tick();
        end
        a_valid0 = 1'b0; v_req0 = 1'b0; flush0 = 1'b0;
        check("busy_len", cnt, 16);
        check("post_flush_vv", int'(vv0), 0);
        m_clear(0);
        vic0(0, 0, "flushed_s0");
        vic0(9, 0, "flushed_s9");
        vic0(15, 0, "flushed_s15");
        vic0(1, 0, "flushed_s1");

        // ---------------- reset in mid-flush ----------------
        acc0(2, 0);
        vic0(2, 2, "pre_rst_s2");
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        check("flush_c5_busy", int'(busy0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy0), 0);
        check("async_vv", int'(vv0), 0);
        check("async_vw", int'(vw0), 0);
        #4;
        rst_n = 1'b1;
        m_reset_all();
        for (int s = 0; s < 16; s++) begin
            vic0(s, 0, "after_rst");
        end
        check("after_rst_busy", int'(busy0), 0);

        // ---------------- random, all instances ----------------
        for (int c = 0; c < 300; c++) begin
            same = $urandom_range(0, 3);
            a_valid0 = 1'($urandom_range(0, 1));
            a_set0   = 4'($urandom_range(0, 15));
            a_way0   = 2'($urandom_range(0, 3));
            v_req0   = 1'($urandom_range(0, 1));
            v_set0   = (same == 0) ? a_set0 : 4'($urandom_range(0, 15));
            a_valid1 = 1'($urandom_range(0, 1));
            a_set1   = 3'($urandom_range(0, 7));
            a_way1   = 4'($urandom_range(0, 15));
            v_req1   = 1'($urandom_range(0, 1));
            v_set1   = (same == 1) ? a_set1 : 3'($urandom_range(0, 7));
            a_valid2 = 1'($urandom_range(0, 1));
            a_set2   = 2'($urandom_range(0, 3));
            a_way2   = 1'($urandom_range(0, 1));
            v_req2   = 1'($urandom_range(0, 1));
            v_set2   = (same == 2) ? a_set2 : 2'($urandom_range(0, 3));

            if (a_valid0) m_access(0, int'(a_set0), int'(a_way0));
            if (v_req0)   exp_vw[0] = m_victim(0, int'(v_set0));
            if (a_valid1) m_access(1, int'(a_set1), int'(a_way1));
            if (v_req1)   exp_vw[1] = m_victim(1, int'(v_set1));
            if (a_valid2) m_access(2, int'(a_set2), int'(a_way2));
            if (v_req2)   exp_vw[2] = m_victim(2, int'(v_set2));

            tick();
            check("rnd4_valid", int'(vv0), int'(v_req0));
            check("rnd4_way", int'(vw0), exp_vw[0]);
            check("rnd16_valid", int'(vv1), int'(v_req1));
            check("rnd16_way", int'(vw1), exp_vw[1]);
            check("rnd2_valid", int'(vv2), int'(v_req2));
            check("rnd2_way", int'(vw2), exp_vw[2]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
